// File: rtl/control_pipe.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB) with load-use stall, flush and forwarding select.
// Define CTRL_PIPE_FWD_EN to enable operand forwarding; otherwise fwd is 00 and RAW hazards stall.
module control_pipe (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       RegDst_i,
    input  logic       ALUSrc_i,
    input  logic       MemtoReg_i,
    input  logic       RegWrite_i,
    input  logic       MemRead_i,
    input  logic       MemWrite_i,
    input  logic [1:0] ALUOp_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    input  logic       flush_i,
    output logic       stall_o,
    output logic       ex_RegDst_o,
    output logic       ex_ALUSrc_o,
    output logic [1:0] ex_ALUOp_o,
    output logic       mem_MemRead_o,
    output logic       mem_MemWrite_o,
    output logic [4:0] mem_dest_o,
    output logic       wb_MemtoReg_o,
    output logic       wb_RegWrite_o,
    output logic [4:0] wb_dest_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    logic       ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
    logic [4:0] ex_rt, ex_dest;
    logic       mem_memtoreg, mem_regwrite;
    logic [4:0] id_dest;
    logic       bubble, load_use;

    // Destination is zeroed for non-writers so downstream compares never see stale or X fields.
    assign id_dest = RegWrite_i ? (RegDst_i ? rd_i : rt_i) : 5'd0;
    assign bubble  = stall_o | flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_RegDst_o <= 1'b0;
            ex_ALUSrc_o <= 1'b0;
            ex_ALUOp_o  <= 2'b00;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_rt       <= 5'd0;
            ex_dest     <= 5'd0;
        end else if (bubble) begin
            ex_RegDst_o <= 1'b0;
            ex_ALUSrc_o <= 1'b0;
            ex_ALUOp_o  <= 2'b00;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_rt       <= 5'd0;
            ex_dest     <= 5'd0;
        end else begin
            ex_RegDst_o <= RegDst_i;
            ex_ALUSrc_o <= ALUSrc_i;
            ex_ALUOp_o  <= ALUOp_i;
            ex_memtoreg <= MemtoReg_i;
            ex_regwrite <= RegWrite_i;
            ex_memread  <= MemRead_i;
            ex_memwrite <= MemWrite_i;
            ex_rt       <= rt_i;
            ex_dest     <= id_dest;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_memtoreg   <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_MemRead_o  <= 1'b0;
            mem_MemWrite_o <= 1'b0;
            mem_dest_o     <= 5'd0;
            wb_MemtoReg_o  <= 1'b0;
            wb_RegWrite_o  <= 1'b0;
            wb_dest_o      <= 5'd0;
        end else begin
            mem_memtoreg   <= ex_memtoreg;
            mem_regwrite   <= ex_regwrite;
            mem_MemRead_o  <= ex_memread;
            mem_MemWrite_o <= ex_memwrite;
            mem_dest_o     <= ex_dest;
            wb_MemtoReg_o  <= mem_memtoreg;
            wb_RegWrite_o  <= mem_regwrite;
            wb_dest_o      <= mem_dest_o;
        end
    end

    assign load_use = ex_memread & (ex_rt != 5'd0) & ((ex_rt == rs_i) | (ex_rt == rt_i));

`ifdef CTRL_PIPE_FWD_EN
    logic [4:0] ex_rs;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            ex_rs <= 5'd0;
        else if (bubble)
            ex_rs <= 5'd0;
        else
            ex_rs <= rs_i;
    end

    assign stall_o = load_use;

    // The younger EX/MEM result wins over MEM/WB when both target the same register.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (mem_regwrite && mem_dest_o != 5'd0 && mem_dest_o == ex_rs)
            fwd_a_o = 2'b10;
        else if (wb_RegWrite_o && wb_dest_o != 5'd0 && wb_dest_o == ex_rs)
            fwd_a_o = 2'b01;
        if (mem_regwrite && mem_dest_o != 5'd0 && mem_dest_o == ex_rt)
            fwd_b_o = 2'b10;
        else if (wb_RegWrite_o && wb_dest_o != 5'd0 && wb_dest_o == ex_rt)
            fwd_b_o = 2'b01;
    end
`else
    logic ex_hit, mem_hit;

    // Without forwarding, any pending write to a source in EX or MEM must drain first.
    assign ex_hit  = ex_regwrite & (ex_dest != 5'd0) & ((ex_dest == rs_i) | (ex_dest == rt_i));
    assign mem_hit = mem_regwrite & (mem_dest_o != 5'd0) & ((mem_dest_o == rs_i) | (mem_dest_o == rt_i));
    assign stall_o = load_use | ex_hit | mem_hit;
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed scenarios followed by random traffic,
// all compared against an instruction-level pipeline model.
module tb_control_pipe;

    logic       clk_i, rst_i;
    logic       RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i;
    logic [1:0] ALUOp_i;
    logic [4:0] rs_i, rt_i, rd_i;
    logic       flush_i;
    logic       stall_o, ex_RegDst_o, ex_ALUSrc_o;
    logic [1:0] ex_ALUOp_o;
    logic       mem_MemRead_o, mem_MemWrite_o;
    logic [4:0] mem_dest_o;
    logic       wb_MemtoReg_o, wb_RegWrite_o;
    logic [4:0] wb_dest_o;
    logic [1:0] fwd_a_o, fwd_b_o;

    control_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i),
        .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUOp_i(ALUOp_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_ALUOp_o(ex_ALUOp_o), .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
        .mem_dest_o(mem_dest_o), .wb_MemtoReg_o(wb_MemtoReg_o), .wb_RegWrite_o(wb_RegWrite_o),
        .wb_dest_o(wb_dest_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One record per in-flight instruction; slot 0 is EX, 1 is MEM, 2 is WB.
    typedef struct packed {
        logic       regdst, alusrc;
        logic [1:0] aluop;
        logic       memtoreg, regwrite, memread, memwrite;
        logic [4:0] rs, rt, dest;
    } instr_t;

    instr_t pipe [3];
    int     n_vec = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    logic   last_stall = 1'b0;

    function automatic logic writes_reg(input instr_t i, input logic [4:0] r);
        return i.regwrite && i.dest != 5'd0 && i.dest == r;
    endfunction

    function automatic logic model_stall();
        logic s;
        s = pipe[0].memread && pipe[0].rt != 5'd0 && (pipe[0].rt == rs_i || pipe[0].rt == rt_i);
`ifndef CTRL_PIPE_FWD_EN
        for (int k = 0; k < 2; k++)
            if (writes_reg(pipe[k], rs_i) || writes_reg(pipe[k], rt_i)) s = 1'b1;
`endif
        return s;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef CTRL_PIPE_FWD_EN
        if (writes_reg(pipe[1], src)) return 2'b10;
        if (writes_reg(pipe[2], src)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic void model_advance(input logic kill);
        instr_t n;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        n = '0;
        if (!kill) begin
            n.regdst = RegDst_i;  n.alusrc = ALUSrc_i;  n.aluop = ALUOp_i;
            n.memtoreg = MemtoReg_i; n.regwrite = RegWrite_i;
            n.memread = MemRead_i; n.memwrite = MemWrite_i;
            n.rs = rs_i; n.rt = rt_i;
            n.dest = RegWrite_i ? (RegDst_i ? rd_i : rt_i) : 5'd0;
        end
        pipe[0] = n;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input logic s);
        checkOutput("stall",      {7'd0, stall_o},        {7'd0, s});
        checkOutput("ex_regdst",  {7'd0, ex_RegDst_o},    {7'd0, pipe[0].regdst});
        checkOutput("ex_alusrc",  {7'd0, ex_ALUSrc_o},    {7'd0, pipe[0].alusrc});
        checkOutput("ex_aluop",   {6'd0, ex_ALUOp_o},     {6'd0, pipe[0].aluop});
        checkOutput("mem_read",   {7'd0, mem_MemRead_o},  {7'd0, pipe[1].memread});
        checkOutput("mem_write",  {7'd0, mem_MemWrite_o}, {7'd0, pipe[1].memwrite});
        checkOutput("mem_dest",   {3'd0, mem_dest_o},     {3'd0, pipe[1].dest});
        checkOutput("wb_memtoreg",{7'd0, wb_MemtoReg_o},  {7'd0, pipe[2].memtoreg});
        checkOutput("wb_regwrite",{7'd0, wb_RegWrite_o},  {7'd0, pipe[2].regwrite});
        checkOutput("wb_dest",    {3'd0, wb_dest_o},      {3'd0, pipe[2].dest});
        checkOutput("fwd_a",      {6'd0, fwd_a_o},        {6'd0, model_fwd(pipe[0].rs)});
        checkOutput("fwd_b",      {6'd0, fwd_b_o},        {6'd0, model_fwd(pipe[0].rt)});
    endtask

    // Called just after a falling edge with the ID inputs already driven.
    task automatic applyStimulus();
        logic s;
        #1;
        s = model_stall();
        checkAll(s);
        n_vec++;
        last_stall = s & ~flush_i;
        @(posedge clk_i);
        model_advance(s | flush_i);
        @(negedge clk_i);
    endtask

    task automatic setIns(input logic regdst, alusrc, input logic [1:0] aluop,
                          input logic memtoreg, regwrite, memread, memwrite,
                          input logic [4:0] rs, rt, rd, input logic flush);
        RegDst_i = regdst; ALUSrc_i = alusrc; ALUOp_i = aluop;
        MemtoReg_i = memtoreg; RegWrite_i = regwrite;
        MemRead_i = memread; MemWrite_i = memwrite;
        rs_i = rs; rt_i = rt; rd_i = rd; flush_i = flush;
    endtask

    task automatic setIdle();
        setIns(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic setAdd(input logic [4:0] rs, rt, rd);
        setIns(1, 0, 2'b10, 0, 1, 0, 0, rs, rt, rd, 0);
    endtask

    task automatic setLw(input logic [4:0] rs, rt, input logic flush);
        setIns(0, 1, 2'b00, 1, 1, 1, 0, rs, rt, 5'd0, flush);
    endtask

    task automatic drainStall();
        for (int k = 0; k < 4 && model_stall(); k++) applyStimulus();
    endtask

    initial begin
        model_reset();
        setIdle();
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkAll(1'b0);
        n_vec++;
        rst_i = 1'b1;

        // Add r3 then three idle cycles: result visible at WB three edges later.
        setAdd(5'd1, 5'd2, 5'd3);
        applyStimulus();
        setIdle();
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("add_wb_regwrite", {7'd0, wb_RegWrite_o}, 8'd1);
        checkOutput("add_wb_dest",     {3'd0, wb_dest_o},     8'd3);
        applyStimulus();

        // Load-use: one stall, then a bubble in EX.
        setLw(5'd1, 5'd5, 0);
        applyStimulus();
        setAdd(5'd5, 5'd6, 5'd7);
        #1;
        checkOutput("loaduse_stall", {7'd0, stall_o}, 8'd1);
        applyStimulus();
        #1;
        checkOutput("bubble_aluop",  {6'd0, ex_ALUOp_o},  8'd0);
        checkOutput("bubble_regdst", {7'd0, ex_RegDst_o}, 8'd0);
        drainStall();
        applyStimulus();
        setIdle();
        repeat (3) applyStimulus();

        // Forwarding distance 1, distance 2, and both older writers on r4.
        setAdd(5'd1, 5'd2, 5'd4);
        applyStimulus();
        setAdd(5'd4, 5'd4, 5'd9);
        drainStall();
        applyStimulus();
`ifdef CTRL_PIPE_FWD_EN
        #1;
        checkOutput("fwd_dist1_a", {6'd0, fwd_a_o}, 8'h2);
        checkOutput("fwd_dist1_b", {6'd0, fwd_b_o}, 8'h2);
`endif
        setAdd(5'd1, 5'd2, 5'd4);
        applyStimulus();
        setIdle();
        applyStimulus();
        setAdd(5'd4, 5'd4, 5'd9);
        drainStall();
        applyStimulus();
`ifdef CTRL_PIPE_FWD_EN
        #1;
        checkOutput("fwd_dist2_a", {6'd0, fwd_a_o}, 8'h1);
`endif
        setAdd(5'd1, 5'd2, 5'd4);
        applyStimulus();
        applyStimulus();
        setAdd(5'd4, 5'd4, 5'd9);
        drainStall();
        applyStimulus();
`ifdef CTRL_PIPE_FWD_EN
        #1;
        checkOutput("fwd_both_a", {6'd0, fwd_a_o}, 8'h2);
`endif
        setIdle();
        repeat (3) applyStimulus();

        // Writes to r0 never forward or stall.
        setIns(0, 1, 2'b00, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 0);
        applyStimulus();
        setAdd(5'd0, 5'd0, 5'd8);
        #1;
        checkOutput("r0_stall", {7'd0, stall_o}, 8'd0);
        applyStimulus();
        #1;
        checkOutput("r0_fwd_a", {6'd0, fwd_a_o}, 8'd0);
        setIdle();
        repeat (3) applyStimulus();

        // Flush kills a load in ID; flush together with stall yields one bubble.
        setLw(5'd1, 5'd5, 1);
        applyStimulus();
        setIdle();
        applyStimulus();
        #1;
        checkOutput("flush_memread", {7'd0, mem_MemRead_o}, 8'd0);
        setLw(5'd1, 5'd5, 0);
        applyStimulus();
        setAdd(5'd5, 5'd0, 5'd7);
        flush_i = 1'b1;
        applyStimulus();
        setIdle();
        repeat (3) applyStimulus();

        // Reset mid-pipeline with three instructions in flight.
        setAdd(5'd1, 5'd2, 5'd10);
        applyStimulus();
        setAdd(5'd1, 5'd2, 5'd11);
        applyStimulus();
        setLw(5'd2, 5'd12, 0);
        applyStimulus();
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        checkAll(1'b0);
        n_vec++;
        @(negedge clk_i);
        rst_i = 1'b1;
        setAdd(5'd1, 5'd2, 5'd13);
        applyStimulus();
        setIdle();
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("post_reset_wb_dest", {3'd0, wb_dest_o}, 8'd13);
        applyStimulus();

        // Random traffic; a stalled instruction is re-presented, as IF/ID would hold it.
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                setIns(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'b0);
            end
            flush_i = ($urandom_range(0, 7) == 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
